// File: rtl/t07_mmio_bus_bridge.sv
// t07_mmio_bus_bridge
//   Bus-side stage behind the CPU memory handler. A request from the handler
//   (rwi_i: 01 write, 10 read, 11 fetch) is latched, range-checked and run as
//   a single Wishbone-classic transfer. busy tells the handler a transfer is
//   in flight; its 1->0 edge marks completion, after which dataMMIO_o (and
//   instr_o for fetches) hold the result until the next read/fetch completes.
//   Transfers that are never acknowledged are aborted after TIMEOUT cycles,
//   and out-of-range requests finish without touching the bus. Both cases
//   return ERR_DATA to loads/fetches and set the sticky err_o flag.
//
// Ports
//   clk, nrst        clock (posedge) and synchronous active-low reset
//   rwi_i            request op from the handler (00 idle)
//   addr_i, wdata_i  request byte address and write data
//   dataMMIO_o       read data returned for loads and fetches
//   instr_o          last fetched instruction word
//   busy             transfer in flight
//   err_o            sticky timeout / range error flag
//   wb_*_o, wb_*_i   Wishbone-classic master interface (32-bit, full-word)
module t07_mmio_bus_bridge #(
  parameter logic [31:0] ADDR_LO  = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI  = 32'h00FF_FFFF,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  rwi_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] dataMMIO_o,
  output logic [31:0] instr_o,
  output logic        busy,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_FETCH = 2'b11;
  localparam logic [15:0] TO_CNT   = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] data_q, data_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  // Range check via 33-bit differences: the borrow bit tells which side of
  // the bound the address lies on, without a degenerate compare when a
  // bound is 0 or all-ones.
  logic [32:0] lo_diff;
  logic [32:0] hi_diff;
  logic        in_range;

  assign lo_diff  = {1'b0, addr_i} - {1'b0, ADDR_LO};
  assign hi_diff  = {1'b0, ADDR_HI} - {1'b0, addr_i};
  assign in_range = ~lo_diff[32] & ~hi_diff[32];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    data_d  = data_q;
    instr_d = instr_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (rwi_i != 2'b00) begin
          op_d   = rwi_i;
          adr_d  = {addr_i[31:2], 2'b00};
          wdat_d = wdata_i;
          busy_d = 1'b1;
          if (in_range) begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = (rwi_i == OP_WRITE);
            cnt_d   = 16'd1;
          end else begin
            // No bus cycle: busy is high only for the single DONE cycle.
            state_d = S_DONE;
            err_d   = 1'b1;
            if (rwi_i[1]) begin
              data_d = ERR_DATA;
            end
          end
        end
      end

      S_BUS: begin
        // Ack is tested first so that it wins over a simultaneous timeout.
        if (wb_ack_i) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = 16'd0;
          if (op_q[1]) begin
            data_d = wb_dat_i;
          end
          if (op_q == OP_FETCH) begin
            instr_d = wb_dat_i;
          end
        end else if (cnt_q == TO_CNT) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = 16'd0;
          err_d   = 1'b1;
          if (op_q[1]) begin
            data_d = ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DONE: begin
        // One quiet cycle so a held request is not re-accepted immediately
        // and the handler always sees busy fall.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      adr_q   <= 32'd0;
      wdat_q  <= 32'd0;
      cnt_q   <= 16'd0;
      busy_q  <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= 32'd0;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      data_q  <= data_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign dataMMIO_o = data_q;
  assign instr_o    = instr_q;
  assign busy       = busy_q;
  assign err_o      = err_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = wdat_q;
  assign wb_sel_o   = 4'hF;

endmodule

// File: tb/tb_t07_mmio_bus_bridge.sv
module tb_t07_mmio_bus_bridge;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [1:0]  rwi = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] dataMMIO, instr;
  logic        busy, err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dato;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dati = 32'd0;
  logic        wb_ack = 1'b0;

  int cmp_n = 0;
  int mis_n = 0;

  always #5 clk = ~clk;

  t07_mmio_bus_bridge #(
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .rwi_i(rwi),
    .addr_i(addr),
    .wdata_i(wdata),
    .dataMMIO_o(dataMMIO),
    .instr_o(instr),
    .busy(busy),
    .err_o(err),
    .wb_cyc_o(wb_cyc),
    .wb_stb_o(wb_stb),
    .wb_we_o(wb_we),
    .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dato),
    .wb_sel_o(wb_sel),
    .wb_dat_i(wb_dati),
    .wb_ack_i(wb_ack)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] instr;
    logic        err;
    int          busy_cyc;
    logic        bus;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          gap;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_n++;
    if (act !== req) begin
      mis_n++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Slave: acks on the slv_lat-th cycle of a strobe; slv_lat=0 never acks.
  int          slv_lat = 0;
  logic [31:0] slv_rdata = 32'd0;
  int          slv_cnt = 0;

  always @(negedge clk) begin
    if (wb_cyc && wb_stb) begin
      slv_cnt++;
      wb_ack  = (slv_lat != 0) && (slv_cnt == slv_lat);
      wb_dati = wb_ack ? slv_rdata : 32'h0BAD_0BAD;
    end else begin
      slv_cnt = 0;
      wb_ack  = 1'b0;
      wb_dati = 32'h0BAD_0BAD;
    end
  end

  // Monitor: measures each busy pulse and the bus activity under it, and on
  // every busy fall compares against the next scoreboard entry.
  logic        m_prev = 1'b0;
  int          m_hi = 0;
  int          m_gap = 0;
  int          m_gap_rise = -1;
  logic        m_seen = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_adr = 32'd0;
  logic [31:0] m_dat = 32'd0;
  logic [3:0]  m_sel = 4'd0;

  always @(negedge clk) begin
    if (!nrst) begin
      m_prev = 1'b0; m_hi = 0; m_gap = 0; m_gap_rise = -1; m_seen = 1'b0;
    end else begin
      if (busy) begin
        if (!m_prev) m_gap_rise = m_gap;
        m_hi++;
      end else if (m_prev) begin
        if (exp_q.size() == 0) begin
          cmp_n++; mis_n++;
          $display("FAIL unexpected_completion: got busy fall required none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dataMMIO", dataMMIO, e.data);
          check("instr", instr, e.instr);
          check("err", 32'(err), 32'(e.err));
          check("busy_cycles", 32'(m_hi), 32'(e.busy_cyc));
          check("bus_cycle_seen", 32'(m_seen), 32'(e.bus));
          if (e.bus) begin
            check("wb_adr", m_adr, e.adr);
            check("wb_we", 32'(m_we), 32'(e.we));
            check("wb_sel", 32'(m_sel), 32'hF);
            if (e.we) check("wb_dat", m_dat, e.wdat);
          end
          if (e.gap >= 0) check("idle_gap", 32'(m_gap_rise), 32'(e.gap));
        end
        m_hi = 0; m_gap = 1; m_seen = 1'b0;
      end else begin
        m_gap++;
      end
      if (wb_cyc) begin
        m_seen = 1'b1; m_we = wb_we; m_adr = wb_adr; m_dat = wb_dato; m_sel = wb_sel;
      end
      m_prev = busy;
    end
  end

  task automatic wait_busy(input logic val, input string name);
    int i;
    for (i = 0; i < 60 && busy !== val; i++) @(negedge clk);
    if (busy !== val) begin
      cmp_n++; mis_n++;
      $display("FAIL %s: got busy=%b required %b within 60 cycles", name, busy, val);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] ins, input logic e, input int bc,
                      input logic b, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input int g);
    exp_t x;
    x.data = d; x.instr = ins; x.err = e; x.busy_cyc = bc; x.bus = b;
    x.we = w; x.adr = a; x.wdat = wd; x.gap = g;
    exp_q.push_back(x);
  endtask

  task automatic xfer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input int lat, input logic [31:0] rd, input string name);
    @(negedge clk);
    rwi = op; addr = a; wdata = wd; slv_lat = lat; slv_rdata = rd;
    @(negedge clk);
    rwi = 2'b00;
    wait_busy(1'b0, name);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dato, 32'd0);
    check("rst_data", dataMMIO, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'hF);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch, ack on 3rd strobe cycle.
    push(32'h0050_0093, 32'h0050_0093, 1'b0, 3, 1'b1, 1'b0, 32'h40, 32'h0, -1);
    xfer(2'b11, 32'h40, 32'h0, 3, 32'h0050_0093, "fetch");
    // Unaligned write: address forced to word boundary, read data untouched.
    push(32'h0050_0093, 32'h0050_0093, 1'b0, 1, 1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, -1);
    xfer(2'b01, 32'h103, 32'hCAFE_F00D, 1, 32'h1111_1111, "write");
    // Out-of-range read: no bus cycle, one busy cycle, error data.
    push(32'hDEAD_BEEF, 32'h0050_0093, 1'b1, 1, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    xfer(2'b10, 32'h0100_0000, 32'h0, 1, 32'h2222_2222, "range_err");
    // Read with no ack: aborted after TIMEOUT=4 cycles.
    push(32'hDEAD_BEEF, 32'h0050_0093, 1'b1, 4, 1'b1, 1'b0, 32'h200, 32'h0, -1);
    xfer(2'b10, 32'h200, 32'h0, 0, 32'h0, "timeout_read");
    // Next request serviced normally.
    push(32'h1234_5678, 32'h0050_0093, 1'b1, 2, 1'b1, 1'b0, 32'h204, 32'h0, -1);
    xfer(2'b10, 32'h204, 32'h0, 2, 32'h1234_5678, "read_after_timeout");
    // Ack on the same edge as the timeout: ack wins.
    push(32'hA5A5_0001, 32'hA5A5_0001, 1'b1, 4, 1'b1, 1'b0, 32'h300, 32'h0, -1);
    xfer(2'b11, 32'h300, 32'h0, 4, 32'hA5A5_0001, "ack_vs_timeout");
    // Fetch timeout leaves instr_o alone.
    push(32'hDEAD_BEEF, 32'hA5A5_0001, 1'b1, 4, 1'b1, 1'b0, 32'h500, 32'h0, -1);
    xfer(2'b11, 32'h500, 32'h0, 0, 32'h0, "fetch_timeout");

    // Held read request: two transfers with a two-cycle busy-low gap.
    push(32'h1111_2222, 32'hA5A5_0001, 1'b1, 1, 1'b1, 1'b0, 32'h10, 32'h0, -1);
    push(32'h1111_2222, 32'hA5A5_0001, 1'b1, 1, 1'b1, 1'b0, 32'h10, 32'h0, 2);
    @(negedge clk);
    rwi = 2'b10; addr = 32'h10; slv_lat = 1; slv_rdata = 32'h1111_2222;
    @(negedge clk);
    wait_busy(1'b0, "held_first_done");
    wait_busy(1'b1, "held_second_start");
    rwi = 2'b00;
    wait_busy(1'b0, "held_second_done");
    repeat (3) @(negedge clk);

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    rwi = 2'b10; addr = 32'h400; slv_lat = 0;
    @(negedge clk);
    rwi = 2'b00;
    repeat (2) @(negedge clk);
    check("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    check("midrst_cyc", 32'(wb_cyc), 32'd0);
    check("midrst_stb", 32'(wb_stb), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_data", dataMMIO, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_sel", 32'(wb_sel), 32'hF);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    push(32'h0000_0077, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h8, 32'h0, -1);
    xfer(2'b10, 32'h8, 32'h0, 1, 32'h0000_0077, "read_after_reset");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required finish before 200000");
    $fatal(1);
  end

endmodule
